// File: rtl/moore_pattern_detector.sv
// Parametrised Moore serial pattern detector with a KMP transition table built
// at elaboration and a saturating counter of entries into the MATCH state.
module moore_pattern_detector #(
  parameter int unsigned          PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter bit                   OVERLAP   = 1'b1,
  parameter int unsigned          CNT_W     = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             valid_i,
  input  logic                             in_i,
  input  logic                             clear_i,
  output logic                             match_o,
  output logic [$clog2(PATTERN_W+1)-1:0]   progress_o,
  output logic [CNT_W-1:0]                 hits_o
);

  localparam int unsigned SW      = $clog2(PATTERN_W + 1);
  localparam int unsigned N_ST    = 1 << SW;
  localparam logic [SW-1:0] S_MATCH = SW'(PATTERN_W);

  // Longest suffix of (prefix_k, b) that is also a pattern prefix; MATCH without
  // overlap restarts from the empty prefix. Encodings above MATCH map to S0.
  function automatic int unsigned kmp_next(input int unsigned k, input int unsigned b);
    int unsigned pat;
    int unsigned kk;
    int unsigned s;
    int unsigned res;
    pat = 32'(PATTERN);
    res = 0;
    if (k <= PATTERN_W) begin
      kk = (k == PATTERN_W && !OVERLAP) ? 0 : k;
      s  = ((pat >> (PATTERN_W - kk)) << 1) | b;
      for (int unsigned l = 1; l <= PATTERN_W; l++) begin
        if (l <= kk + 1 && (s & ((32'd1 << l) - 32'd1)) == (pat >> (PATTERN_W - l)))
          res = l;
      end
    end
    return res;
  endfunction

  logic [SW-1:0]    w_nxt [N_ST][2];
  logic [SW-1:0]    r_state;
  logic [SW-1:0]    w_state_nxt;
  logic             w_hit;
  logic             r_match;
  logic [CNT_W-1:0] r_hits;

  for (genvar k = 0; k < N_ST; k++) begin : g_tbl
    localparam logic [SW-1:0] NXT0 = SW'(kmp_next(k, 0));
    localparam logic [SW-1:0] NXT1 = SW'(kmp_next(k, 1));
    assign w_nxt[k][0] = NXT0;
    assign w_nxt[k][1] = NXT1;
  end

  // Next-state and hit decode
  always_comb begin
    w_state_nxt = r_state;
    w_hit       = 1'b0;
    if (r_state > S_MATCH)
      w_state_nxt = '0;
    else if (valid_i)
      w_state_nxt = w_nxt[r_state][in_i];
    w_hit = (w_state_nxt == S_MATCH) && ((r_state != S_MATCH) || valid_i);
  end

  // State, Moore match flag and saturating hit counter
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      r_state <= '0;
      r_match <= 1'b0;
      r_hits  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_match <= (w_state_nxt == S_MATCH);
      if (w_hit && (r_hits != '1))
        r_hits <= r_hits + CNT_W'(1);
    end
  end

  assign match_o    = r_match;
  assign progress_o = r_state;
  assign hits_o     = r_hits;

endmodule

// File: tb/tb_moore_pattern_detector.sv
// Scoreboard bench: three detector configurations share one input stream and are
// compared each cycle against a bit-history reference model.
module tb_moore_pattern_detector;

  logic clk = 1'b0;
  logic reset, clear, valid, din;

  logic       m_a, m_b, m_c;
  logic [2:0] p_a, p_b;
  logic [1:0] p_c;
  logic [7:0] h_a, h_b;
  logic [1:0] h_c;

  always #5 clk = ~clk;

  moore_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .CNT_W(8)) u_a (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .in_i(din), .clear_i(clear),
    .match_o(m_a), .progress_o(p_a), .hits_o(h_a));
  moore_pattern_detector #(.PATTERN_W(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .CNT_W(8)) u_b (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .in_i(din), .clear_i(clear),
    .match_o(m_b), .progress_o(p_b), .hits_o(h_b));
  moore_pattern_detector #(.PATTERN_W(2), .PATTERN(2'b11), .OVERLAP(1'b1), .CNT_W(2)) u_c (
    .clk_i(clk), .reset_i(reset), .valid_i(valid), .in_i(din), .clear_i(clear),
    .match_o(m_c), .progress_o(p_c), .hits_o(h_c));

  typedef struct packed {
    logic [2:0]      m;
    logic [2:0][4:0] p;
    logic [2:0][7:0] h;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;

  // Reference model: accepted bit history per configuration
  int pat  [3] = '{11, 11, 3};
  int pw   [3] = '{4, 4, 2};
  int ovl  [3] = '{1, 0, 1};
  int cmax [3] = '{255, 255, 3};
  int hv   [3];
  int hl   [3];
  int st   [3];
  int hits [3];

  function automatic int longest(input int i);
    for (int l = pw[i]; l >= 1; l--) begin
      if (hl[i] >= l) begin
        bit ok = 1'b1;
        for (int j = 0; j < l; j++)
          if (((hv[i] >> (l - 1 - j)) & 1) != ((pat[i] >> (pw[i] - 1 - j)) & 1)) ok = 1'b0;
        if (ok) return l;
      end
    end
    return 0;
  endfunction

  function automatic exp_t model_step(input bit rst, input bit clr, input bit v, input bit b);
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (rst || clr) begin
        hv[i] = 0; hl[i] = 0; st[i] = 0; hits[i] = 0;
      end else if (v) begin
        if (ovl[i] == 0 && st[i] == pw[i]) begin
          hv[i] = 0; hl[i] = 0;
        end
        hv[i] = ((hv[i] << 1) | int'(b)) & 16'hffff;
        hl[i] = (hl[i] < 16) ? hl[i] + 1 : 16;
        st[i] = longest(i);
        if (st[i] == pw[i] && hits[i] < cmax[i]) hits[i]++;
      end
      e.m[i] = (st[i] == pw[i]);
      e.p[i] = 5'(st[i]);
      e.h[i] = 8'(hits[i]);
    end
    return e;
  endfunction

  task automatic step(input bit rst, input bit clr, input bit v, input bit b);
    @(negedge clk);
    reset = rst; clear = clr; valid = v; din = b;
    sb.push_back(model_step(rst, clr, v, b));
  endtask

  task automatic feed(input int n, input logic [15:0] bits);
    for (int i = n - 1; i >= 0; i--) step(1'b0, 1'b0, 1'b1, bits[i]);
  endtask

  function automatic void chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act != exp_v)
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", name, cyc, act, exp_v);
    else
      n_pass++;
  endfunction

  // Monitor: one expected response per clock edge
  initial begin
    forever begin
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("A.match", int'(m_a), int'(e.m[0]));
        chk("A.progress", int'(p_a), int'(e.p[0]));
        chk("A.hits", int'(h_a), int'(e.h[0]));
        chk("B.match", int'(m_b), int'(e.m[1]));
        chk("B.progress", int'(p_b), int'(e.p[1]));
        chk("B.hits", int'(h_b), int'(e.h[1]));
        chk("C.match", int'(m_c), int'(e.m[2]));
        chk("C.progress", int'(p_c), int'(e.p[2]));
        chk("C.hits", int'(h_c), int'(e.h[2]));
      end
    end
  end

  initial begin
    reset = 1'b0; clear = 1'b0; valid = 1'b0; din = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // reset mid-stream
    feed(3, 16'b101);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    // overlap / non-overlap stream
    feed(7, 16'b1011011);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    // valid gaps
    feed(2, 16'b10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'($urandom));
    feed(2, 16'b11);
    step(1'b0, 1'b0, 1'b0, 1'($urandom));
    // saturation on the 2-bit configuration
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(8, 16'hff);
    // clear colliding with a completing bit
    step(1'b1, 1'b0, 1'b0, 1'b0);
    feed(3, 16'b101);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      int r = int'($urandom_range(0, 999));
      step(r < 4, (r >= 4 && r < 12), ($urandom_range(0, 3) != 0), 1'($urandom));
    end
    @(negedge clk);
    valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_chk++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
